// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath (GPRs, HI/LO, PC, IR, Y, Z, MAR, MDR, ALU) driven by one-hot strobes.
// Optional feature macro: DATAPATH_R0_HARDZERO_EN makes R0 read as zero and ignore R0in.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             PCout,
  input  logic             IRout,
  input  logic             MDRout,
  input  logic             INout,
  input  logic             Cout,
  input  logic             Yout,
  input  logic             MARout,
  input  logic             Read,
  input  logic             IncPC,
  input  logic             AND,
  input  logic             OR,
  input  logic             ADD,
  input  logic             SUB,
  input  logic             MUL,
  input  logic             DIV,
  input  logic             SHR,
  input  logic             SHRA,
  input  logic             SHL,
  input  logic             ROR,
  input  logic             ROL,
  input  logic             NEG,
  input  logic             NOT,
  input  logic             R0in,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             Zin,
  input  logic             Yin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] PC
);

  localparam int SHW = $clog2(WIDTH);

  logic [15:0]          r_out, r_in;
  logic [WIDTH-1:0]     r_q [16];
  logic [WIDTH-1:0]     r_d [16];
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
  logic [WIDTH-1:0]     y_q, y_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [2*WIDTH-1:0]   z_q, z_d, alu_c;
  logic [WIDTH-1:0]     bus, c_sext;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [SHW-1:0]       amt;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Bus mux: sources are visited lowest priority first so the highest asserted one lands last.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path leaves it unassigned (no latch).
    c_sext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
    bus    = '0;
    if (MARout)   bus = mar_q;
    if (Yout)     bus = y_q;
    if (Cout)     bus = c_sext;
    if (INout)    bus = IN;
    if (MDRout)   bus = mdr_q;
    if (IRout)    bus = ir_q;
    if (PCout)    bus = pc_q;
    if (Zlowout)  bus = z_q[WIDTH-1:0];
    if (Zhighout) bus = z_q[2*WIDTH-1:WIDTH];
    if (LOout)    bus = lo_q;
    if (HIout)    bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
`ifdef DATAPATH_R0_HARDZERO_EN
    if (R0out) bus = '0;
`endif
  end

  // ALU: A = Y, B = bus; first asserted op in port order wins.
  always_comb begin
    a_s   = y_q;
    b_s   = bus;
    amt   = bus[SHW-1:0];
    alu_c = '0;
    if (AND)       alu_c[WIDTH-1:0] = y_q & bus;
    else if (OR)   alu_c[WIDTH-1:0] = y_q | bus;
    else if (ADD)  alu_c[WIDTH-1:0] = y_q + bus;
    else if (SUB)  alu_c[WIDTH-1:0] = y_q - bus;
    else if (MUL)  alu_c = $signed({{WIDTH{a_s[WIDTH-1]}}, a_s}) *
                           $signed({{WIDTH{b_s[WIDTH-1]}}, b_s});
    else if (DIV) begin
      if (bus == '0) alu_c = {y_q, {WIDTH{1'b1}}};
      else           alu_c = {a_s % b_s, a_s / b_s};
    end
    else if (SHR)  alu_c[WIDTH-1:0] = y_q >> amt;
    else if (SHRA) alu_c[WIDTH-1:0] = a_s >>> amt;
    else if (SHL)  alu_c[WIDTH-1:0] = y_q << amt;
    // A shift by WIDTH yields zero, so amount 0 leaves the rotate result equal to A.
    else if (ROR)  alu_c[WIDTH-1:0] = (y_q >> amt) | (y_q << (WIDTH - amt));
    else if (ROL)  alu_c[WIDTH-1:0] = (y_q << amt) | (y_q >> (WIDTH - amt));
    else if (NEG)  alu_c[WIDTH-1:0] = '0 - bus;
    else if (NOT)  alu_c[WIDTH-1:0] = ~bus;
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      r_d[i] = r_in[i] ? bus : r_q[i];
    end
`ifdef DATAPATH_R0_HARDZERO_EN
    r_d[0] = '0;
`endif
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    ir_d  = IRin  ? bus : ir_q;
    y_d   = Yin   ? bus : y_q;
    mar_d = MARin ? bus : mar_q;
    mdr_d = MDRin ? (Read ? IN : bus) : mdr_q;
    z_d   = Zin   ? alu_c : z_q;
    pc_d  = pc_q;
    if (PCin) pc_d = IncPC ? pc_q + WIDTH'(1) : bus;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the whole register file is cleared on reset, so this array is built from flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples values from before the edge.
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      y_q   <= y_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      z_q   <= z_d;
    end
  end

  assign BusMuxOut = bus;
  assign PC        = pc_q;

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: randomized and directed checks of the single-bus datapath against a behavioural model.
`timescale 1ns/100ps
module tb_datapath;

  localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_IR = 21,
                 S_MDR = 22, S_IN = 23, S_C = 24, S_Y = 25, S_MAR = 26;
  localparam int D_HI = 16, D_LO = 17, D_PC = 18, D_IR = 19, D_Z = 20, D_Y = 21,
                 D_MAR = 22, D_MDR = 23;
  localparam int OP_AND = 0, OP_ADD = 2, OP_SUB = 3, OP_MUL = 4, OP_DIV = 5, OP_SHR = 6,
                 OP_SHRA = 7, OP_SHL = 8, OP_ROR = 9, OP_ROL = 10, OP_NEG = 11, OP_NOT = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] rout = '0, rin = '0;
  logic        hi_out = 0, lo_out = 0, zh_out = 0, zl_out = 0, pc_out = 0, ir_out = 0;
  logic        mdr_out = 0, in_out = 0, c_out = 0, y_out = 0, mar_out = 0;
  logic        read = 0, inc_pc = 0;
  logic [12:0] op = '0;
  logic        hi_in = 0, lo_in = 0, pc_in = 0, ir_in = 0, z_in = 0, y_in = 0, mar_in = 0, mdr_in = 0;
  logic [31:0] in_data = '0;
  logic [31:0] bus, pc;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr;
  logic [63:0] m_z;

  always #10 clk = ~clk;

  datapath #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(hi_out), .LOout(lo_out), .Zhighout(zh_out), .Zlowout(zl_out), .PCout(pc_out),
    .IRout(ir_out), .MDRout(mdr_out), .INout(in_out), .Cout(c_out), .Yout(y_out),
    .MARout(mar_out), .Read(read), .IncPC(inc_pc),
    .AND(op[0]), .OR(op[1]), .ADD(op[2]), .SUB(op[3]), .MUL(op[4]), .DIV(op[5]),
    .SHR(op[6]), .SHRA(op[7]), .SHL(op[8]), .ROR(op[9]), .ROL(op[10]), .NEG(op[11]),
    .NOT(op[12]),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(hi_in), .LOin(lo_in), .PCin(pc_in), .IRin(ir_in), .Zin(z_in), .Yin(y_in),
    .MARin(mar_in), .MDRin(mdr_in),
    .IN(in_data), .BusMuxOut(bus), .PC(pc)
  );

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0; m_y = '0; m_mar = '0; m_mdr = '0; m_z = '0;
  endtask

  task automatic model_load(input int dst, input logic [31:0] v);
    if (dst < 16) begin
`ifdef DATAPATH_R0_HARDZERO_EN
      if (dst != 0) m_r[dst] = v;
`else
      m_r[dst] = v;
`endif
    end else begin
      case (dst)
        D_HI:  m_hi  = v;
        D_LO:  m_lo  = v;
        D_PC:  m_pc  = v;
        D_IR:  m_ir  = v;
        D_Y:   m_y   = v;
        D_MAR: m_mar = v;
        D_MDR: m_mdr = v;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] model_src(input int s);
    logic [31:0] low19;
    low19 = m_ir & 32'h0007FFFF;
    if (s < 16) begin
`ifdef DATAPATH_R0_HARDZERO_EN
      if (s == 0) return 32'h0;
`endif
      return m_r[s];
    end
    case (s)
      S_HI:  return m_hi;
      S_LO:  return m_lo;
      S_ZH:  return m_z[63:32];
      S_ZL:  return m_z[31:0];
      S_PC:  return m_pc;
      S_IR:  return m_ir;
      S_MDR: return m_mdr;
      S_IN:  return in_data;
      S_C:   return m_ir[18] ? (low19 | 32'hFFF80000) : low19;
      S_Y:   return m_y;
      S_MAR: return m_mar;
      default: return 32'h0;
    endcase
  endfunction

  // Reference ALU from arithmetic rules: shifts and rotates are done one bit at a time.
  function automatic logic [63:0] alu_ref(input int opi, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [31:0] r;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    r  = a;
    case (opi)
      0: return {32'h0, a & b};
      1: return {32'h0, a | b};
      2: return {32'h0, a + b};
      3: return {32'h0, a - b};
      4: return sa * sb;
      5: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      6:  begin repeat (n) r = {1'b0, r[31:1]};  return {32'h0, r}; end
      7:  begin repeat (n) r = {r[31], r[31:1]}; return {32'h0, r}; end
      8:  begin repeat (n) r = {r[30:0], 1'b0};  return {32'h0, r}; end
      9:  begin repeat (n) r = {r[0], r[31:1]};  return {32'h0, r}; end
      10: begin repeat (n) r = {r[30:0], r[31]}; return {32'h0, r}; end
      11: return {32'h0, 32'h0 - b};
      12: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_out();
    rout = '0; hi_out = 0; lo_out = 0; zh_out = 0; zl_out = 0; pc_out = 0; ir_out = 0;
    mdr_out = 0; in_out = 0; c_out = 0; y_out = 0; mar_out = 0;
  endtask

  task automatic clear_ctrl();
    clear_out();
    rin = '0; hi_in = 0; lo_in = 0; pc_in = 0; ir_in = 0; z_in = 0; y_in = 0; mar_in = 0;
    mdr_in = 0; read = 0; inc_pc = 0; op = '0;
  endtask

  task automatic set_out(input int s);
    if (s < 16) rout[s] = 1'b1;
    else case (s)
      S_HI: hi_out = 1; S_LO: lo_out = 1; S_ZH: zh_out = 1; S_ZL: zl_out = 1;
      S_PC: pc_out = 1; S_IR: ir_out = 1; S_MDR: mdr_out = 1; S_IN: in_out = 1;
      S_C: c_out = 1; S_Y: y_out = 1; S_MAR: mar_out = 1;
      default: ;
    endcase
  endtask

  task automatic set_in(input int d);
    if (d < 16) rin[d] = 1'b1;
    else case (d)
      D_HI: hi_in = 1; D_LO: lo_in = 1; D_PC: pc_in = 1; D_IR: ir_in = 1;
      D_Z: z_in = 1; D_Y: y_in = 1; D_MAR: mar_in = 1; D_MDR: mdr_in = 1;
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  task automatic peek(input int s, output logic [31:0] v);
    set_out(s);
    #0.2;
    v = bus;
    clear_out();
  endtask

  task automatic load_in(input int d, input logic [31:0] v);
    in_data = v;
    in_out  = 1'b1;
    set_in(d);
    cycle();
    model_load(d, v);
  endtask

  task automatic alu_run(input int opi, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] z);
    logic [31:0] lo, hi;
    load_in(D_Y, a);
    in_data = b;
    in_out  = 1'b1;
    if (opi >= 0) op[opi] = 1'b1;
    z_in = 1'b1;
    cycle();
    m_z = (opi >= 0) ? alu_ref(opi, a, b) : 64'h0;
    peek(S_ZL, lo);
    peek(S_ZH, hi);
    z = {hi, lo};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    clear_ctrl();
    in_data = '0;
    #2 reset = 1'b1;
    #3;
    model_reset();
    n_tests++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    for (int s = 0; s < 27; s++) begin
      peek(s, v);
      n_tests++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_src%0d: got %h want 00000000", s, v); end
    end
    @(negedge clk);
    reset = 1'b0;
    cycle();
  endtask

  task automatic mdr_load(input int idx, input logic [31:0] v);
    in_data = v; read = 1'b1; mdr_in = 1'b1;
    cycle();
    mdr_out = 1'b1; rin[idx] = 1'b1;
    cycle();
    m_mdr = v;
    model_load(idx, v);
  endtask

  task automatic test_shr_sequence();
    logic [31:0] v;
    mdr_load(3, 32'h22);
    mdr_load(7, 32'h04);
    mdr_load(4, 32'h28);
    in_data = 32'h4A1B8000; inc_pc = 1; pc_in = 1; mar_in = 1; read = 1; mdr_in = 1;  // T0
    cycle();
    mdr_out = 1; ir_in = 1; cycle();              // T1
    rout[3] = 1; y_in = 1; cycle();               // T2
    rout[7] = 1; op[OP_SHR] = 1; z_in = 1; cycle(); // T3
    zl_out = 1; rin[4] = 1; cycle();              // T4
    m_pc = 32'h1; m_mar = 32'h0; m_mdr = 32'h4A1B8000; m_ir = 32'h4A1B8000;
    m_y = 32'h22; m_z = 64'h2; m_r[4] = 32'h2;
    peek(4, v);
    n_tests++;
    if (v !== 32'h00000002) begin n_fail++; $display("FAIL shr_r4: got %h want 00000002", v); end
    n_tests++;
    if (pc !== 32'h1) begin n_fail++; $display("FAIL shr_pc: got %h want 00000001", pc); end
    peek(S_IR, v);
    n_tests++;
    if (v !== 32'h4A1B8000) begin n_fail++; $display("FAIL shr_ir: got %h want 4a1b8000", v); end
    peek(S_MAR, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL shr_mar: got %h want 00000000", v); end
    peek(S_C, v);
    n_tests++;
    if (v !== 32'h00038000) begin n_fail++; $display("FAIL shr_cpos: got %h want 00038000", v); end
  endtask

  typedef struct {
    int          opi;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } alu_vec_t;

  task automatic test_alu_directed();
    alu_vec_t    vecs [15];
    logic [63:0] z;
    vecs = '{
      '{OP_ADD,  32'h7FFFFFFF, 32'h1,        64'h00000000_80000000},
      '{OP_SUB,  32'h5,        32'h7,        64'h00000000_FFFFFFFE},
      '{OP_MUL,  32'hFFFFFFFE, 32'h3,        64'hFFFFFFFF_FFFFFFFA},
      '{OP_DIV,  32'hFFFFFFF9, 32'h2,        64'hFFFFFFFF_FFFFFFFD},
      '{OP_DIV,  32'h9,        32'h0,        64'h00000009_FFFFFFFF},
      '{OP_SHRA, 32'h80000001, 32'h1,        64'h00000000_C0000000},
      '{OP_ROR,  32'h80000001, 32'h1,        64'h00000000_C0000000},
      '{OP_ROL,  32'h80000001, 32'h1,        64'h00000000_00000003},
      '{OP_SHL,  32'h80000001, 32'h1,        64'h00000000_00000002},
      '{OP_SHR,  32'h80000001, 32'h0,        64'h00000000_80000001},
      '{OP_ROL,  32'h80000001, 32'h20,       64'h00000000_80000001},
      '{OP_NEG,  32'h12345678, 32'h1,        64'h00000000_FFFFFFFF},
      '{OP_NOT,  32'h12345678, 32'h0,        64'h00000000_FFFFFFFF},
      '{-1,      32'h12345678, 32'h9ABCDEF0, 64'h0},
      '{OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000}
    };
    foreach (vecs[i]) begin
      alu_run(vecs[i].opi, vecs[i].a, vecs[i].b, z);
      n_tests++;
      if (z !== vecs[i].z) begin
        n_fail++;
        $display("FAIL alu_dir%0d op%0d: got %h want %h", i, vecs[i].opi, z, vecs[i].z);
      end
    end
  endtask

  task automatic test_alu_priority();
    logic [31:0] v;
    load_in(D_Y, 32'hF0F0F0F0);
    in_data = 32'h0FF00FF0; in_out = 1; op[OP_AND] = 1; op[OP_ADD] = 1; z_in = 1;
    cycle();
    m_z = 64'h00F000F0;
    peek(S_ZL, v);
    n_tests++;
    if (v !== 32'h00F000F0) begin n_fail++; $display("FAIL alu_prio: got %h want 00f000f0", v); end
  endtask

  task automatic test_alu_random();
    logic [63:0] z, exp;
    logic [31:0] a, b;
    int opi;
    for (int i = 0; i < 40; i++) begin
      opi = int'($urandom_range(0, 12));
      a = $urandom;
      b = $urandom;
      if (opi == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'h7FFFFFFF;
      exp = alu_ref(opi, a, b);
      alu_run(opi, a, b, z);
      n_tests++;
      if (z !== exp) begin
        n_fail++;
        $display("FAIL alu_rand op%0d a=%h b=%h: got %h want %h", opi, a, b, z, exp);
      end
    end
  endtask

  task automatic test_hilo();
    logic [63:0] z;
    logic [31:0] v;
    alu_run(OP_MUL, 32'hFFFFFFFE, 32'h3, z);
    zh_out = 1; hi_in = 1; cycle(); m_hi = m_z[63:32];
    zl_out = 1; lo_in = 1; cycle(); m_lo = m_z[31:0];
    peek(S_HI, v);
    n_tests++;
    if (v !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL hi_move: got %h want ffffffff", v); end
    peek(S_LO, v);
    n_tests++;
    if (v !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL lo_move: got %h want fffffffa", v); end
  endtask

  task automatic test_bus_priority();
    logic [31:0] v, r2v;
    r2v = $urandom;
    load_in(2, r2v);
    load_in(D_MDR, ~r2v);
    #0.2;
    n_tests++;
    if (bus !== 32'h0) begin n_fail++; $display("FAIL bus_idle: got %h want 00000000", bus); end
    rout[2] = 1; mdr_out = 1; #0.2; v = bus; clear_out();
    n_tests++;
    if (v !== r2v) begin n_fail++; $display("FAIL bus_r2_mdr: got %h want %h", v, r2v); end
    load_in(D_HI, 32'hA5A5A5A5);
    load_in(D_LO, 32'h5A5A5A5A);
    hi_out = 1; lo_out = 1; #0.2; v = bus; clear_out();
    n_tests++;
    if (v !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bus_hi_lo: got %h want a5a5a5a5", v); end
    load_in(D_IR, 32'h00040000);
    peek(S_C, v);
    n_tests++;
    if (v !== 32'hFFFC0000) begin n_fail++; $display("FAIL bus_cneg: got %h want fffc0000", v); end
  endtask

  task automatic test_pc();
    logic [31:0] v;
    load_in(D_PC, 32'h10);
    inc_pc = 1; pc_in = 1; cycle();
    n_tests++;
    if (pc !== 32'h11) begin n_fail++; $display("FAIL pc_inc: got %h want 00000011", pc); end
    inc_pc = 1; cycle();
    n_tests++;
    if (pc !== 32'h11) begin n_fail++; $display("FAIL pc_inc_noload: got %h want 00000011", pc); end
    in_data = 32'h55; in_out = 1; inc_pc = 1; pc_in = 1; cycle();
    m_pc = 32'h12;
    peek(S_PC, v);
    n_tests++;
    if (v !== 32'h12) begin n_fail++; $display("FAIL pc_inc_over_bus: got %h want 00000012", v); end
  endtask

  task automatic test_r0();
    logic [31:0] v, exp;
    load_in(0, 32'hDEADBEEF);
`ifdef DATAPATH_R0_HARDZERO_EN
    exp = 32'h0;
`else
    exp = 32'hDEADBEEF;
`endif
    peek(0, v);
    n_tests++;
    if (v !== exp) begin n_fail++; $display("FAIL r0_read: got %h want %h", v, exp); end
  endtask

  task automatic test_regs_random();
    logic [31:0] v, val;
    int d, d2;
    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 23));
      if (d == D_Z) d = D_Y;
      load_in(d, $urandom);
    end
    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(1, 15));
      d2 = (d % 15) + 1;
      val = $urandom;
      in_data = val; in_out = 1; rin[d] = 1; rin[d2] = 1;
      cycle();
      model_load(d, val);
      model_load(d2, val);
    end
    in_data = $urandom;
    for (int s = 0; s < 27; s++) begin
      peek(s, v);
      n_tests++;
      if (v !== model_src(s)) begin
        n_fail++;
        $display("FAIL regs_src%0d: got %h want %h", s, v, model_src(s));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    load_in(5, 32'h1234);
    load_in(D_PC, 32'h7);
    n_tests++;
    if (pc !== 32'h7) begin n_fail++; $display("FAIL rmid_pc_pre: got %h want 00000007", pc); end
    in_data = '0;
    #4 reset = 1'b1;
    #0.5;
    model_reset();
    n_tests++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL rmid_pc: got %h want 00000000", pc); end
    for (int s = 0; s < 27; s++) begin
      peek(s, v);
      n_tests++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL rmid_src%0d: got %h want 00000000", s, v); end
    end
    @(negedge clk);
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_shr_sequence();
    test_alu_directed();
    test_alu_priority();
    test_alu_random();
    test_hilo();
    test_bus_priority();
    test_pc();
    test_r0();
    test_regs_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
